// File: rtl/iir_out_framer.sv
// iir_out_framer: scales and saturates the IIR filter output, groups non-zero
// bursts into sof/eof-marked frames and buffers them in a first-word-fall-through
// FIFO that drains over a valid/ready interface.
// Build option: define IIR_FRAMER_ROUND_EN to round half up before the shift
// (default build truncates toward minus infinity).
module iir_out_framer #(
  parameter int unsigned IN_W       = 17,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned IDLE_GAP   = 3,
  parameter int unsigned MAX_LEN    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  y_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ZR_W  = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned ENT_W = OUT_W + 2;
  localparam int unsigned EXT_W = IN_W + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef IIR_FRAMER_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND = (SHIFT > 0) ? EXT_W'(1 << (SHIFT - 1)) : '0;
`endif

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // stage 1
  logic [OUT_W-1:0]          scaled_q, scaled_d;
  logic                      nz_q, nz_d;
  logic signed [EXT_W-1:0]   ext, shifted;

  // framing FSM
  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [ZR_W-1:0]           zrun_q, zrun_d;
  logic                      wr_req, wr_sof, wr_eof;

  // FIFO
  logic [ENT_W-1:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [ENT_W-1:0]          head_q, head_d, wr_entry;
  logic                      valid_q, valid_d;
  logic                      ovf_q, ovf_d;
  logic [7:0]                frame_cnt_q, frame_cnt_d;
  logic                      full, rd_en, wr_en;

  // Scale (optional rounding, arithmetic shift) and saturate; nz uses the raw sample
  always_comb begin
    ext = {y_in[IN_W-1], y_in};
`ifdef IIR_FRAMER_ROUND_EN
    ext = ext + RND;
`endif
    shifted = ext >>> SHIFT;
    if (shifted > SAT_MAX) begin
      scaled_d = OUT_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      scaled_d = OUT_W'(SAT_MIN);
    end else begin
      scaled_d = OUT_W'(shifted);
    end
    nz_d = (y_in != '0);
  end

  // Frame FSM: open on non-zero, close on IDLE_GAP zeros or MAX_LEN samples
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    zrun_d  = zrun_q;
    wr_req  = 1'b0;
    wr_sof  = 1'b0;
    wr_eof  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nz_q) begin
          wr_req = 1'b1;
          wr_sof = 1'b1;
          len_d  = LEN_W'(1);
          zrun_d = '0;
          if (MAX_LEN == 1) begin
            wr_eof = 1'b1;
          end else begin
            state_d = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        wr_req = 1'b1;
        len_d  = len_q + LEN_W'(1);
        zrun_d = nz_q ? '0 : zrun_q + ZR_W'(1);
        if ((zrun_d == ZR_W'(IDLE_GAP)) || (len_d == LEN_W'(MAX_LEN))) begin
          wr_eof  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // FIFO control; a write into a full FIFO survives only if a read frees a slot
  always_comb begin
    wr_entry    = {wr_sof, wr_eof, scaled_q};
    full        = (count_q == CNT_W'(FIFO_DEPTH));
    rd_en       = valid_q & out_ready;
    wr_en       = wr_req & (~full | rd_en);
    ovf_d       = ovf_q | (wr_req & full & ~rd_en);
    frame_cnt_d = frame_cnt_q + ((wr_en & wr_eof) ? 8'd1 : 8'd0);
    wr_ptr_d    = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    valid_d     = (count_d != '0);
    // Registered head: bypass the entry being written when it lands in the head slot
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_entry;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // State register for all stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled_q    <= '0;
      nz_q        <= 1'b0;
      state_q     <= S_IDLE;
      len_q       <= '0;
      zrun_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      scaled_q    <= scaled_d;
      nz_q        <= nz_d;
      state_q     <= state_d;
      len_q       <= len_d;
      zrun_q      <= zrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_entry;
      end
    end
  end

  assign out_data  = head_q[OUT_W-1:0];
  assign out_sof   = head_q[ENT_W-1];
  assign out_eof   = head_q[ENT_W-2];
  assign out_valid = valid_q;
  assign ovf       = ovf_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_iir_out_framer.sv
// Bench for iir_out_framer: three instances (default, MAX_LEN=4, SHIFT=2) share
// one stimulus stream; a frame/queue model is compared every cycle, plus
// hand-computed transfer sequences for each scenario.
module tb_iir_out_framer;

  localparam int NI    = 3;
  localparam int GAP   = 3;
  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [16:0] y_in = '0;
  logic [7:0]         od [NI];
  logic               os [NI];
  logic               oe [NI];
  logic               ov [NI];
  logic               oo [NI];
  logic [7:0]         fc [NI];

  int mlen [NI] = '{255, 4, 255};
  int msh  [NI] = '{0, 0, 2};

  int n_pass = 0;
  int n_total = 0;

  iir_out_framer u0 (.clk(clk), .rst_n(rst_n), .y_in(y_in), .out_data(od[0]), .out_sof(os[0]),
                     .out_eof(oe[0]), .out_valid(ov[0]), .out_ready(out_ready), .ovf(oo[0]),
                     .frame_cnt(fc[0]));
  iir_out_framer #(.MAX_LEN(4)) u1 (.clk(clk), .rst_n(rst_n), .y_in(y_in), .out_data(od[1]),
                     .out_sof(os[1]), .out_eof(oe[1]), .out_valid(ov[1]), .out_ready(out_ready),
                     .ovf(oo[1]), .frame_cnt(fc[1]));
  iir_out_framer #(.SHIFT(2)) u2 (.clk(clk), .rst_n(rst_n), .y_in(y_in), .out_data(od[2]),
                     .out_sof(os[2]), .out_eof(oe[2]), .out_valid(ov[2]), .out_ready(out_ready),
                     .ovf(oo[2]), .frame_cnt(fc[2]));

  always #5 clk = ~clk;

  // Divide by 2^s with floor (or round half up), then clamp to 8-bit signed
  function automatic int scale(input int y, input int s);
    int d, q, v;
    d = 1 << s;
    v = y;
`ifdef IIR_FRAMER_ROUND_EN
    if (s > 0) v = v + d / 2;
`endif
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  // Model state: per-instance frame tracker and ring buffer of expected entries
  int mdat [NI][DEPTH];
  bit msof [NI][DEPTH];
  bit meof [NI][DEPTH];
  int mhead [NI];
  int msize [NI];
  int mfc [NI];
  bit movf [NI];
  bit minf [NI];
  int mflen [NI];
  int mztr [NI];
  int prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        mhead[i] <= 0; msize[i] <= 0; mfc[i] <= 0; movf[i] <= 1'b0;
        minf[i] <= 1'b0; mflen[i] <= 0; mztr[i] <= 0;
      end
      prev <= 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit rd, wr, sf, ef, inf;
        int len, zr, sz, hd;
        sz = msize[i]; hd = mhead[i]; len = mflen[i]; zr = mztr[i]; inf = minf[i];
        rd = (sz > 0) && out_ready;
        wr = 1'b0; sf = 1'b0; ef = 1'b0;
        if (!inf) begin
          if (prev != 0) begin
            wr = 1'b1; sf = 1'b1; len = 1; zr = 0;
            if (len >= mlen[i]) ef = 1'b1; else inf = 1'b1;
          end
        end else begin
          wr = 1'b1;
          len = len + 1;
          zr = (prev == 0) ? zr + 1 : 0;
          if (zr >= GAP || len >= mlen[i]) begin ef = 1'b1; inf = 1'b0; end
        end
        if (rd) begin hd = (hd + 1) % DEPTH; sz = sz - 1; end
        if (wr) begin
          if (sz < DEPTH) begin
            mdat[i][(hd + sz) % DEPTH] <= scale(prev, msh[i]);
            msof[i][(hd + sz) % DEPTH] <= sf;
            meof[i][(hd + sz) % DEPTH] <= ef;
            sz = sz + 1;
            if (ef) mfc[i] <= (mfc[i] + 1) % 256;
          end else begin
            movf[i] <= 1'b1;
          end
        end
        msize[i] <= sz; mhead[i] <= hd; mflen[i] <= len; mztr[i] <= zr; minf[i] <= inf;
      end
      prev <= int'(y_in);
    end
  end

  // Transfer log per instance
  int ldat [NI][256];
  bit lsof [NI][256];
  bit leof [NI][256];
  int lcnt [NI];

  always @(posedge clk) begin
    if (rst_n && out_ready) begin
      for (int i = 0; i < NI; i++) begin
        if (ov[i]) begin
          ldat[i][lcnt[i] % 256] <= int'($signed(od[i]));
          lsof[i][lcnt[i] % 256] <= os[i];
          leof[i][lcnt[i] % 256] <= oe[i];
          lcnt[i] <= lcnt[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total = n_total + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d valid", i), int'(ov[i]), int'(msize[i] > 0));
      if (msize[i] > 0) begin
        chk($sformatf("u%0d data", i), int'($signed(od[i])), mdat[i][mhead[i]]);
        chk($sformatf("u%0d sof", i), int'(os[i]), int'(msof[i][mhead[i]]));
        chk($sformatf("u%0d eof", i), int'(oe[i]), int'(meof[i][mhead[i]]));
      end
      chk($sformatf("u%0d ovf", i), int'(oo[i]), int'(movf[i]));
      chk($sformatf("u%0d frame_cnt", i), int'(fc[i]), mfc[i]);
    end
  endtask

  task automatic chk_log(input string tag, input int i, input int base, input int ev[$],
                         input bit [15:0] sm, input bit [15:0] em);
    chk($sformatf("%s u%0d transfers", tag, i), lcnt[i] - base, ev.size());
    for (int k = 0; k < ev.size(); k++) begin
      chk($sformatf("%s u%0d data[%0d]", tag, i, k), ldat[i][(base + k) % 256], ev[k]);
      chk($sformatf("%s u%0d sof[%0d]", tag, i, k), int'(lsof[i][(base + k) % 256]), int'(sm[k]));
      chk($sformatf("%s u%0d eof[%0d]", tag, i, k), int'(leof[i][(base + k) % 256]), int'(em[k]));
    end
  endtask

  // Present a sample, then let the edge that samples it pass
  task automatic step(input int v);
    y_in = 17'(v);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int b;
    int ev[$];
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk("reset valid", int'(ov[0]), 0);
    chk("reset data", int'(od[0]), 0);
    chk("reset ovf", int'(oo[0]), 0);
    chk("reset frame_cnt", int'(fc[0]), 0);
    rst_n = 1'b1;

    // Saturating frame, latency of two edges
    out_ready = 1'b1;
    b = lcnt[0];
    step(5);
    chk("t1 valid after 1 edge", int'(ov[0]), 0);
    step(-3);
    chk("t1 valid after 2 edges", int'(ov[0]), 1);
    chk("t1 first data", int'($signed(od[0])), 5);
    chk("t1 first sof", int'(os[0]), 1);
    step(200); step(-300); step(0); step(0); step(0);
    repeat (4) step(0);
    ev = '{5, -3, 127, -128, 0, 0, 0};
    chk_log("t1", 0, b, ev, 16'h0001, 16'h0040);
    chk("t1 frame_cnt", int'(fc[0]), 1);
    chk("t1 ovf", int'(oo[0]), 0);

    // Short zero run inside a frame does not close it
    b = lcnt[0];
    step(7); step(0); step(0); step(9); step(0); step(0); step(0);
    repeat (4) step(0);
    ev = '{7, 0, 0, 9, 0, 0, 0};
    chk_log("t2", 0, b, ev, 16'h0001, 16'h0040);
    chk("t2 frame_cnt", int'(fc[0]), 2);

    // MAX_LEN=4 instance splits a long burst
    b = lcnt[1];
    for (int v = 1; v <= 6; v++) step(v);
    step(0); step(0); step(0);
    repeat (4) step(0);
    ev = '{1, 2, 3, 4, 5, 6, 0, 0};
    chk_log("t3", 1, b, ev, 16'h0011, 16'h0088);
    chk("t3 u1 frame_cnt", int'(fc[1]), 4);

    // Full FIFO with simultaneous read and write: nothing dropped
    out_ready = 1'b0;
    b = lcnt[0];
    for (int v = 11; v <= 19; v++) step(v);
    chk("t5 full valid", int'(ov[0]), 1);
    chk("t5 full ovf", int'(oo[0]), 0);
    out_ready = 1'b1;
    step(20);
    chk("t5 rw ovf", int'(oo[0]), 0);
    chk("t5 rw head", int'($signed(od[0])), 12);
    step(0); step(0); step(0);
    repeat (12) step(0);
    ev = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 0, 0, 0};
    chk_log("t5", 0, b, ev, 16'h0001, 16'h1000);
    chk("t5 ovf after drain", int'(oo[0]), 0);
    chk("t5 frame_cnt", int'(fc[0]), 4);

    // SHIFT=2 instance: floor vs round half up
    b = lcnt[2];
    step(6); step(-6); step(0); step(0); step(0);
    repeat (4) step(0);
`ifdef IIR_FRAMER_ROUND_EN
    ev = '{2, -1, 0, 0, 0};
`else
    ev = '{1, -2, 0, 0, 0};
`endif
    chk_log("t6", 2, b, ev, 16'h0001, 16'h0010);

    // Overflow: burst of 10 with consumer stalled
    out_ready = 1'b0;
    b = lcnt[0];
    for (int v = 1; v <= 9; v++) step(v);
    chk("t4 ovf at full", int'(oo[0]), 0);
    step(10);
    chk("t4 ovf on 9th", int'(oo[0]), 1);
    repeat (6) step(0);
    chk("t4 stalled valid", int'(ov[0]), 1);
    chk("t4 stalled head", int'($signed(od[0])), 1);
    chk("t4 stalled sof", int'(os[0]), 1);
    chk("t4 frame_cnt", int'(fc[0]), 5);
    out_ready = 1'b1;
    repeat (10) step(0);
    ev = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk_log("t4", 0, b, ev, 16'h0001, 16'h0000);
    chk("t4 drained valid", int'(ov[0]), 0);
    chk("t4 ovf sticky", int'(oo[0]), 1);

    // Async reset mid-frame with three entries buffered
    out_ready = 1'b0;
    step(3); step(4); step(5); step(0);
    chk("t7 buffered valid", int'(ov[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("t7 reset valid", int'(ov[0]), 0);
    chk("t7 reset ovf", int'(oo[0]), 0);
    chk("t7 reset frame_cnt", int'(fc[0]), 0);
    chk("t7 reset sof", int'(os[0]), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(9); step(0);
    chk("t7 restart valid", int'(ov[0]), 1);
    chk("t7 restart data", int'($signed(od[0])), 9);
    chk("t7 restart sof", int'(os[0]), 1);
    repeat (5) step(0);
    chk("t7 restart frame_cnt", int'(fc[0]), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
